// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the simple CPU.
// Ports: clk, rst (sync, active-high), run, instr, acc_zero, mem_ack in;
//   start, inc_pc, branch, bus_sel, ir_load, acc_load, alu_op, mem_req,
//   mem_we, mem_addr_sel, halted, err, retired out.
// Option: define ILLEGAL_TRAP_EN to halt with err on opcodes 8-15.
module cpu_sequencer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] instr,
  input  logic              acc_zero,
  input  logic              mem_ack,
  output logic              start,
  output logic              inc_pc,
  output logic              branch,
  output logic [1:0]        bus_sel,
  output logic              ir_load,
  output logic              acc_load,
  output logic [1:0]        alu_op,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_addr_sel,
  output logic              halted,
  output logic              err,
  output logic [15:0]       retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_BRANCH,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_JZ    = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;

  state_t     state;
  state_t     state_n;
  logic [7:0] wait_cnt;
  logic [3:0] opcode;
  logic       ack;
  logic       timeout;
  logic       retire;
  logic       set_err;
  logic       unused_ok;

  assign opcode = instr[DATA_W-1 -: 4];
  // operand bits feed the datapath, not the sequencer
  assign unused_ok = ^{instr[DATA_W-5:ADDR_W], instr[ADDR_W-1:0]};

  // mem_ack only counts while a request is outstanding
  assign ack = mem_req && mem_ack;
  assign timeout = mem_req && !mem_ack &&
                   (wait_cnt == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      err      <= 1'b0;
      retired  <= '0;
    end else begin
      state <= state_n;
      // every ack leaves the waiting state, so clearing on ack or
      // on any non-request cycle covers entry to FETCH/MEM
      if (mem_req && !mem_ack && !timeout)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;
      if (set_err)
        err <= 1'b1;
      if (retire)
        retired <= retired + 16'd1;
    end
  end

  always_comb begin
    state_n = state;
    retire  = 1'b0;
    set_err = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run)
          state_n = S_START;
      end
      S_START: begin
        state_n = S_FETCH;
      end
      S_FETCH: begin
        if (timeout) begin
          set_err = 1'b1;
          state_n = S_HALTED;
        end else if (ack) begin
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP: begin
            retire  = 1'b1;
            state_n = S_FETCH;
          end
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB: begin
            state_n = S_MEM;
          end
          OP_JMP: begin
            state_n = S_BRANCH;
          end
          OP_JZ: begin
            if (acc_zero) begin
              state_n = S_BRANCH;
            end else begin
              retire  = 1'b1;
              state_n = S_FETCH;
            end
          end
          OP_HALT: begin
            retire  = 1'b1;
            state_n = S_HALTED;
          end
          default: begin
`ifdef ILLEGAL_TRAP_EN
            set_err = 1'b1;
            state_n = S_HALTED;
`else
            retire  = 1'b1;
            state_n = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM: begin
        if (timeout) begin
          set_err = 1'b1;
          state_n = S_HALTED;
        end else if (ack) begin
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_BRANCH: begin
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_HALTED: begin
        if (run)
          state_n = S_START;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_comb begin
    start        = 1'b0;
    inc_pc       = 1'b0;
    branch       = 1'b0;
    bus_sel      = 2'd0;
    ir_load      = 1'b0;
    acc_load     = 1'b0;
    alu_op       = 2'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    halted       = 1'b0;
    unique case (state)
      S_START: begin
        start = 1'b1;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        bus_sel = 2'd3;
        ir_load = mem_ack;
        inc_pc  = mem_ack;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_STORE);
        bus_sel      = (opcode == OP_STORE) ? 2'd2 : 2'd3;
        if (opcode == OP_ADD)
          alu_op = 2'd1;
        else if (opcode == OP_SUB)
          alu_op = 2'd2;
        acc_load = mem_ack && (opcode != OP_STORE);
      end
      S_BRANCH: begin
        bus_sel = 2'd1;
        branch  = 1'b1;
      end
      S_HALTED: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer.
// Models PC, IR and a delayed-ack memory; checks pulse events in order.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        acc_zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        start;
  logic        inc_pc;
  logic        branch;
  logic [1:0]  bus_sel;
  logic        ir_load;
  logic        acc_load;
  logic [1:0]  alu_op;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        halted;
  logic        err;
  logic [15:0] retired;

  cpu_sequencer #(
    .DATA_W(16),
    .ADDR_W(6),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .instr(instr),
    .acc_zero(acc_zero),
    .mem_ack(mem_ack),
    .start(start),
    .inc_pc(inc_pc),
    .branch(branch),
    .bus_sel(bus_sel),
    .ir_load(ir_load),
    .acc_load(acc_load),
    .alu_op(alu_op),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel),
    .halted(halted),
    .err(err),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // event = {start,inc_pc,branch,ir_load,acc_load,alu_op,bus_sel,mem_we}
  localparam logic [9:0] EV_START = 10'b1_0_0_0_0_00_00_0;
  localparam logic [9:0] EV_FETCH = 10'b0_1_0_1_0_00_11_0;
  localparam logic [9:0] EV_LOAD  = 10'b0_0_0_0_1_00_11_0;
  localparam logic [9:0] EV_ADD   = 10'b0_0_0_0_1_01_11_0;
  localparam logic [9:0] EV_STORE = 10'b0_0_0_0_0_00_10_1;
  localparam logic [9:0] EV_BR    = 10'b0_0_1_0_0_00_01_0;

  logic [9:0]  exp_q[$];
  logic [15:0] prog[64];
  logic [5:0]  pc = '0;
  int          checks = 0;
  int          errors = 0;
  int          ack_delay = 1;
  bit          hang = 1'b0;
  int          inc_cnt = 0;
  int          acc_cnt = 0;

  // PC / IR register model
  initial forever begin
    @(posedge clk);
    if (start)
      pc <= 6'd1;
    else if (branch)
      pc <= instr[5:0];
    else if (inc_pc)
      pc <= pc + 6'd1;
    if (ir_load)
      instr <= prog[pc];
    if (inc_pc)
      inc_cnt++;
    if (acc_load)
      acc_cnt++;
  end

  // memory responder: ack after ack_delay waiting cycles
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req && !hang) begin
        if (cnt == ack_delay) begin
          mem_ack = 1'b1;
          cnt = 0;
        end else begin
          mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic [9:0] obs;
    logic [9:0] want;
    forever begin
      @(negedge clk);
      if (start | inc_pc | branch | ir_load | acc_load |
          (mem_req & mem_ack)) begin
        obs = {start, inc_pc, branch, ir_load, acc_load,
               alu_op, bus_sel, mem_we};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event: got %b, none expected", obs);
        end else begin
          want = exp_q.pop_front();
          if (obs !== want) begin
            errors++;
            $display("FAIL event: got %b want %b", obs, want);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++)
      prog[i] = 16'h7000;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int n;
    n = 0;
    while (!halted && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("reset_outs",
        {start, inc_pc, branch, bus_sel, ir_load, acc_load, alu_op,
         mem_req, mem_we, mem_addr_sel, halted, err}, 32'd0);
    chk("reset_retired", retired, 32'd0);

    // straight-line LOAD, ADD, STORE, HALT
    clear_prog();
    prog[1] = 16'h1010;
    prog[2] = 16'h3011;
    prog[3] = 16'h2012;
    prog[4] = 16'h7000;
    inc_cnt = 0;
    acc_cnt = 0;
    exp_q.push_back(EV_START);
    exp_q.push_back(EV_FETCH);
    exp_q.push_back(EV_LOAD);
    exp_q.push_back(EV_FETCH);
    exp_q.push_back(EV_ADD);
    exp_q.push_back(EV_FETCH);
    exp_q.push_back(EV_STORE);
    exp_q.push_back(EV_FETCH);
    pulse_run();
    chk("start_pulse", {31'd0, start}, 32'd1);
    @(negedge clk);
    chk("fetch_req", {mem_req, mem_we, mem_addr_sel, bus_sel},
        32'b1_0_0_11);
    chk("fetch_quiet", {start, inc_pc, branch, acc_load, retired},
        32'd0);
    wait_halt("prog1_halt");
    chk("prog1_retired", retired, 32'd4);
    chk("prog1_inc_pc", inc_cnt, 32'd4);
    chk("prog1_acc_load", acc_cnt, 32'd2);
    chk("prog1_err", {31'd0, err}, 32'd0);

    // JZ not taken, JMP, then JZ taken after restart from HALTED
    do_reset();
    clear_prog();
    prog[1] = 16'h6008;
    prog[2] = 16'h500A;
    prog[10] = 16'h7000;
    acc_zero = 1'b0;
    exp_q.push_back(EV_START);
    exp_q.push_back(EV_FETCH);
    exp_q.push_back(EV_FETCH);
    exp_q.push_back(EV_BR);
    exp_q.push_back(EV_FETCH);
    pulse_run();
    wait_halt("jmp_halt");
    chk("jmp_retired", retired, 32'd3);
    clear_prog();
    prog[1] = 16'h600C;
    prog[12] = 16'h7000;
    acc_zero = 1'b1;
    exp_q.push_back(EV_START);
    exp_q.push_back(EV_FETCH);
    exp_q.push_back(EV_BR);
    exp_q.push_back(EV_FETCH);
    pulse_run();
    chk("restart_start", {31'd0, start}, 32'd1);
    wait_halt("jz_halt");
    chk("jz_retired", retired, 32'd5);
    acc_zero = 1'b0;

    // memory stall of 5 cycles
    do_reset();
    clear_prog();
    prog[1] = 16'h0000;
    ack_delay = 5;
    exp_q.push_back(EV_START);
    exp_q.push_back(EV_FETCH);
    exp_q.push_back(EV_FETCH);
    pulse_run();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wait", {mem_req, ir_load, inc_pc}, 32'b100);
    end
    @(negedge clk);
    chk("stall_ack", {mem_req, ir_load, inc_pc}, 32'b111);
    wait_halt("stall_halt");
    chk("stall_retired", retired, 32'd2);
    ack_delay = 1;

    // timeout: no ack ever
    do_reset();
    hang = 1'b1;
    exp_q.push_back(EV_START);
    pulse_run();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("to_wait", {mem_req, err, halted}, 32'b100);
    end
    @(negedge clk);
    chk("to_halt", {mem_req, err, halted}, 32'b011);
    hang = 1'b0;
    do_reset();
    chk("to_rst", {err, halted, mem_req, start}, 32'd0);

    // illegal opcode 0xA
    clear_prog();
    prog[1] = 16'hA000;
    exp_q.push_back(EV_START);
    exp_q.push_back(EV_FETCH);
`ifndef ILLEGAL_TRAP_EN
    exp_q.push_back(EV_FETCH);
`endif
    pulse_run();
    wait_halt("ill_halt");
`ifdef ILLEGAL_TRAP_EN
    chk("ill_retired", retired, 32'd0);
    chk("ill_err", {31'd0, err}, 32'd1);
`else
    chk("ill_retired", retired, 32'd2);
    chk("ill_err", {31'd0, err}, 32'd0);
`endif

    // reset in the middle of a MEM transfer
    do_reset();
    clear_prog();
    prog[1] = 16'h1010;
    ack_delay = 3;
    exp_q.push_back(EV_START);
    exp_q.push_back(EV_FETCH);
    pulse_run();
    begin
      int n;
      n = 0;
      while (!(mem_req && mem_addr_sel) && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("mem_reached", {31'd0, mem_addr_sel}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem", {mem_req, mem_addr_sel, retired}, 32'd0);
    rst = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
